// File: rtl/gate_vector_sequencer.sv
// rtl/gate_vector_sequencer.sv - built-in self-test sequencer for the AND/NOR/AND/NAND gate block (optional FAIL_CAPTURE_EN)
module gate_vector_sequencer #(
    parameter int SETTLE_CYCLES = 1,
    parameter int NUM_PASSES    = 1,
    parameter int CNT_W         = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             gate_a,
    output logic             gate_b,
    input  logic             gate_c,
    input  logic             gate_d,
    input  logic             gate_e,
    input  logic             gate_g,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] err_count,
    output logic [1:0]       vec_idx
`ifdef FAIL_CAPTURE_EN
    ,
    output logic             fail_valid,
    output logic [1:0]       fail_vec,
    output logic [3:0]       fail_obs
`endif
);

    localparam int SET_W  = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES + 1) : 1;
    localparam int PASS_W = (NUM_PASSES > 1) ? $clog2(NUM_PASSES) : 1;
    localparam logic [SET_W-1:0]  SETTLE_LOAD = SET_W'(SETTLE_CYCLES);
    localparam logic [PASS_W-1:0] LAST_PASS   = PASS_W'(NUM_PASSES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_SAMPLE,
        S_DONE
    } state_t;

    state_t            state;
    state_t            state_nx;
    logic [SET_W-1:0]  settle_cnt;
    logic [PASS_W-1:0] pass_cnt;
    logic [3:0]        expected;
    logic [3:0]        observed;
    logic              mismatch;
    logic              last_vec;
    logic              last_pass;

    // Gate drives come straight from the registered vector index, so they are glitch-free.
    assign gate_a = vec_idx[1];
    assign gate_b = vec_idx[0];
    assign pass   = done & (err_count == '0);

    // Truth table of the gate block for the currently driven vector, ordered {c,d,e,g}.
    always_comb begin
        expected  = {gate_a & gate_b, ~(gate_a | gate_b), gate_a & gate_b, ~(gate_a & gate_b)};
        observed  = {gate_c, gate_d, gate_e, gate_g};
        mismatch  = (observed != expected);
        last_vec  = (vec_idx == 2'd3);
        last_pass = (pass_cnt == LAST_PASS);
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic: each vector spends SETTLE_CYCLES in SETTLE then one cycle in SAMPLE.
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nx = S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (settle_cnt == SET_W'(1)) begin
                    state_nx = S_SAMPLE;
                end
            end
            S_SAMPLE: begin
                if (last_vec && last_pass) begin
                    state_nx = S_DONE;
                end else begin
                    state_nx = S_SETTLE;
                end
            end
            S_DONE: begin
                state_nx = S_IDLE;
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    // Datapath: vector stepping, settle/pass counters, saturating error count and status flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            settle_cnt <= '0;
            pass_cnt   <= '0;
            vec_idx    <= 2'd0;
            err_count  <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
`ifdef FAIL_CAPTURE_EN
            fail_valid <= 1'b0;
            fail_vec   <= 2'd0;
            fail_obs   <= 4'd0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        err_count  <= '0;
                        done       <= 1'b0;
                        vec_idx    <= 2'd0;
                        settle_cnt <= SETTLE_LOAD;
                        pass_cnt   <= '0;
                        busy       <= 1'b1;
`ifdef FAIL_CAPTURE_EN
                        fail_valid <= 1'b0;
                        fail_vec   <= 2'd0;
                        fail_obs   <= 4'd0;
`endif
                    end
                end
                S_SETTLE: begin
                    settle_cnt <= settle_cnt - SET_W'(1);
                end
                S_SAMPLE: begin
                    if (mismatch && (err_count != '1)) begin
                        err_count <= err_count + CNT_W'(1);
                    end
`ifdef FAIL_CAPTURE_EN
                    // Only the first failing vector of a run is kept.
                    if (mismatch && !fail_valid) begin
                        fail_valid <= 1'b1;
                        fail_vec   <= vec_idx;
                        fail_obs   <= observed;
                    end
`endif
                    if (!last_vec) begin
                        vec_idx    <= vec_idx + 2'd1;
                        settle_cnt <= SETTLE_LOAD;
                    end else if (!last_pass) begin
                        vec_idx    <= 2'd0;
                        pass_cnt   <= pass_cnt + PASS_W'(1);
                        settle_cnt <= SETTLE_LOAD;
                    end else begin
                        busy <= 1'b0;
                        done <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gate_vector_sequencer.sv
// tb/tb_gate_vector_sequencer.sv - scoreboard bench for gate_vector_sequencer
module tb_gate_vector_sequencer;

    typedef struct {
        logic       busy;
        logic       done;
        logic       a;
        logic       b;
        logic [7:0] err;
    } trace_t;

    typedef struct {
        logic [7:0] err;
        logic       pass;
        int         done_cyc;
        logic       fv;
        logic [1:0] fvec;
        logic [3:0] fobs;
    } result_t;

    logic clk = 1'b0;
    logic rst;
    logic start0, start1;
    int   fault0, fault1;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    trace_t  tq[$];
    result_t rq0[$];
    result_t rq1[$];

    logic       a0, b0, c0, d0, e0, g0, busy0, done0, pass0;
    logic [7:0] err0;
    logic [1:0] vidx0;
    logic       a1, b1, c1, d1, e1, g1, busy1, done1, pass1;
    logic [1:0] err1;
    logic [1:0] vidx1;
`ifdef FAIL_CAPTURE_EN
    logic       fv0, fv1;
    logic [1:0] fvec0, fvec1;
    logic [3:0] fobs0, fobs1;
`endif

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Gate block model with selectable faults: 0 good, 1 g stuck 0, 2 d stuck 1, 3 e behaves as OR.
    function automatic logic [3:0] gate_model(input logic a, input logic b, input int mode);
        logic c, d, e, g;
        c = a & b;
        d = (mode == 2) ? 1'b1 : ~(a | b);
        e = (mode == 3) ? (a | b) : (a & b);
        g = (mode == 1) ? 1'b0 : ~(a & b);
        return {c, d, e, g};
    endfunction

    assign {c0, d0, e0, g0} = gate_model(a0, b0, fault0);
    assign {c1, d1, e1, g1} = gate_model(a1, b1, fault1);

    gate_vector_sequencer u0 (
        .clk(clk), .rst(rst), .start(start0),
        .gate_a(a0), .gate_b(b0), .gate_c(c0), .gate_d(d0), .gate_e(e0), .gate_g(g0),
        .busy(busy0), .done(done0), .pass(pass0), .err_count(err0), .vec_idx(vidx0)
`ifdef FAIL_CAPTURE_EN
        , .fail_valid(fv0), .fail_vec(fvec0), .fail_obs(fobs0)
`endif
    );

    gate_vector_sequencer #(.SETTLE_CYCLES(1), .NUM_PASSES(2), .CNT_W(2)) u1 (
        .clk(clk), .rst(rst), .start(start1),
        .gate_a(a1), .gate_b(b1), .gate_c(c1), .gate_d(d1), .gate_e(e1), .gate_g(g1),
        .busy(busy1), .done(done1), .pass(pass1), .err_count(err1), .vec_idx(vidx1)
`ifdef FAIL_CAPTURE_EN
        , .fail_valid(fv1), .fail_vec(fvec1), .fail_obs(fobs1)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Monitor: trace entries and end-of-run results are popped and compared as the DUTs present them.
    logic done0_q = 1'b0;
    logic done1_q = 1'b0;
    always @(posedge clk) begin
        trace_t  t;
        result_t r;
        #1;
        if (tq.size() > 0) begin
            t = tq.pop_front();
            chk("u0_trace", {20'd0, busy0, done0, a0, b0, err0},
                {20'd0, t.busy, t.done, t.a, t.b, t.err});
        end
        if (done0 && !done0_q) begin
            if (rq0.size() == 0) begin
                chk("u0_unexpected_done", 32'd1, 32'd0);
            end else begin
                r = rq0.pop_front();
                chk("u0_err_count", {24'd0, err0}, {24'd0, r.err});
                chk("u0_pass", {31'd0, pass0}, {31'd0, r.pass});
                chk("u0_done_cycle", cyc, r.done_cyc);
                chk("u0_vec_idx_hold", {30'd0, vidx0}, 32'd3);
`ifdef FAIL_CAPTURE_EN
                chk("u0_fail_capture", {25'd0, fv0, fvec0, fobs0}, {25'd0, r.fv, r.fvec, r.fobs});
`endif
            end
        end
        if (done1 && !done1_q) begin
            if (rq1.size() == 0) begin
                chk("u1_unexpected_done", 32'd1, 32'd0);
            end else begin
                r = rq1.pop_front();
                chk("u1_err_count", {30'd0, err1}, {24'd0, r.err});
                chk("u1_pass", {31'd0, pass1}, {31'd0, r.pass});
                chk("u1_done_cycle", cyc, r.done_cyc);
`ifdef FAIL_CAPTURE_EN
                chk("u1_fail_capture", {25'd0, fv1, fvec1, fobs1}, {25'd0, r.fv, r.fvec, r.fobs});
`endif
            end
        end
        done0_q = done0;
        done1_q = done1;
    end

    function automatic trace_t mk_trace(input logic busy, input logic done, input logic [1:0] v,
                                        input logic [7:0] err);
        trace_t t;
        t.busy = busy; t.done = done; t.a = v[1]; t.b = v[0]; t.err = err;
        return t;
    endfunction

    function automatic result_t mk_res(input logic [7:0] err, input logic pass, input int lat,
                                       input logic fv, input logic [1:0] fvec, input logic [3:0] fobs);
        result_t r;
        r.err = err; r.pass = pass; r.done_cyc = cyc + 1 + lat;
        r.fv = fv; r.fvec = fvec; r.fobs = fobs;
        return r;
    endfunction

    task automatic pulse_start0();
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
    endtask

    task automatic wait_done(input int unit_sel, input int lim);
        int n = 0;
        while (((unit_sel == 0) ? !done0 : !done1) && n < lim) begin
            @(negedge clk);
            n++;
        end
        chk((unit_sel == 0) ? "u0_done_timeout" : "u1_done_timeout",
            {31'd0, (unit_sel == 0) ? done0 : done1}, 32'd1);
    endtask

    initial begin
        rst = 1'b1; start0 = 1'b0; start1 = 1'b0; fault0 = 0; fault1 = 0;
        repeat (2) @(negedge clk);
        tq.push_back(mk_trace(1'b0, 1'b0, 2'd0, 8'd0));
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Clean sweep: busy for 8 cycles, each vector held 2 cycles, then done with pass.
        for (int k = 0; k < 8; k++) tq.push_back(mk_trace(1'b1, 1'b0, 2'(k / 2), 8'd0));
        tq.push_back(mk_trace(1'b0, 1'b1, 2'd3, 8'd0));
        rq0.push_back(mk_res(8'd0, 1'b1, 8, 1'b0, 2'd0, 4'd0));
        pulse_start0();
        wait_done(0, 40);
        @(negedge clk);

        // g stuck at 0: vectors 00, 01, 10 fail.
        fault0 = 1;
        rq0.push_back(mk_res(8'd3, 1'b0, 8, 1'b1, 2'd0, 4'b0100));
        pulse_start0();
        wait_done(0, 40);
        @(negedge clk);

        // e behaves as OR: vectors 01 and 10 fail.
        fault0 = 3;
        rq0.push_back(mk_res(8'd2, 1'b0, 8, 1'b1, 2'd1, 4'b0011));
        pulse_start0();
        wait_done(0, 40);
        @(negedge clk);

        // Reset mid-run aborts with everything cleared and no done.
        fault0 = 0;
        pulse_start0();
        repeat (4) @(negedge clk);
        tq.push_back(mk_trace(1'b0, 1'b0, 2'd0, 8'd0));
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rq0.push_back(mk_res(8'd0, 1'b1, 8, 1'b0, 2'd0, 4'd0));
        pulse_start0();
        wait_done(0, 40);
        @(negedge clk);

        // Start while busy and in DONE is ignored; start from IDLE clears done.
        fault0 = 1;
        rq0.push_back(mk_res(8'd3, 1'b0, 8, 1'b1, 2'd0, 4'b0100));
        pulse_start0();
        repeat (3) @(negedge clk);
        pulse_start0();
        wait_done(0, 40);
        tq.push_back(mk_trace(1'b0, 1'b1, 2'd3, 8'd3));
        pulse_start0();
        @(negedge clk);
        fault0 = 0;
        tq.push_back(mk_trace(1'b1, 1'b0, 2'd0, 8'd0));
        rq0.push_back(mk_res(8'd0, 1'b1, 8, 1'b0, 2'd0, 4'd0));
        pulse_start0();
        wait_done(0, 40);
        @(negedge clk);

        // Two passes with a 2-bit counter: d stuck at 1 gives 6 mismatches, saturating at 3.
        fault1 = 2;
        rq1.push_back(mk_res(8'd3, 1'b0, 16, 1'b1, 2'd1, 4'b0101));
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        wait_done(1, 60);
        @(negedge clk);
        fault1 = 0;
        rq1.push_back(mk_res(8'd0, 1'b1, 16, 1'b0, 2'd0, 4'd0));
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        wait_done(1, 60);

        repeat (3) @(negedge clk);
        chk("trace_queue_drained", tq.size(), 32'd0);
        chk("u0_results_drained", rq0.size(), 32'd0);
        chk("u1_results_drained", rq1.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
